// File: rtl/apb_master.sv
// APB requester: turns single-beat register commands into APB transfers,
// one at a time, with an optional PREADY timeout that aborts a hung access.
//
// Handshake: a command is taken on a PCLK edge where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE and the command fields need to be stable
// only on that edge. rsp_valid is a one-cycle pulse with no backpressure;
// rsp_rdata/rsp_err are meaningful only while rsp_valid is high.
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Counter must hold TIMEOUT_CYCLES-1; keep at least one bit when disabled.
  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  state_t                state_q,     state_d;
  logic                  psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic                  pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and next-output logic for the IDLE -> SETUP -> ACCESS cycle.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          // Address is forced word-aligned; low bits of cmd_addr are dropped.
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr & WORD_MASK;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          state_d     = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          // Completer never answered within the budget: abort with error.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a vector table of single transfers with
// varying wait states, then hand-written timeout, back-to-back, busy and
// mid-transfer reset sequences. Inputs change and outputs are sampled on the
// falling edge of PCLK.
module tb_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  // Clock and watchdog
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  // One complete transfer against a completer inserting `waits` wait states.
  task automatic do_xfer(input string tag, input logic w, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] prdata,
                         input int waits, input logic [31:0] exp_paddr,
                         input logic [31:0] exp_rdata);
    chk({tag, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = addr; cmd_wdata = wdata;
    PREADY = 1'b0; PRDATA = prdata;
    step();
    cmd_valid = 1'b0;
    chk({tag, "_setup_psel"}, PSEL, 1);
    chk({tag, "_setup_penable"}, PENABLE, 0);
    chk({tag, "_setup_paddr"}, PADDR, exp_paddr);
    chk({tag, "_setup_pwrite"}, PWRITE, w);
    chk({tag, "_setup_pwdata"}, PWDATA, wdata);
    chk({tag, "_setup_rsp"}, rsp_valid, 0);
    step();
    for (int k = 0; k <= waits; k++) begin
      chk({tag, "_acc_penable"}, PENABLE, 1);
      chk({tag, "_acc_psel"}, PSEL, 1);
      chk({tag, "_acc_paddr"}, PADDR, exp_paddr);
      chk({tag, "_acc_rsp"}, rsp_valid, 0);
      PREADY = (k == waits);
      step();
    end
    PREADY = 1'b0;
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_psel"}, PSEL, 0);
    chk({tag, "_rsp_penable"}, PENABLE, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_paddr_hold"}, PADDR, exp_paddr);
    step();
    chk({tag, "_rsp_pulse"}, rsp_valid, 0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic [31:0] exp_paddr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] exp_q[$];
    logic        bw[3];
    logic [31:0] ba[3];
    logic [31:0] bd[3];
    int          n_acc, idx, n_rsp, psel_low;
    logic        got;

    vecs[0] = '{1'b1, 32'h0000_0008, 32'h0000_00A5, 32'hDEAD_BEEF, 0, 32'h0000_0008, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_1234, 2, 32'h0000_0004, 32'h0000_1234};
    vecs[2] = '{1'b1, 32'h0000_0013, 32'hCAFE_F00D, 32'h0000_0077, 1, 32'h0000_0010, 32'h0};
    vecs[3] = '{1'b0, 32'hFFFF_FFFE, 32'h1111_2222, 32'h8000_0001, 3, 32'hFFFF_FFFC, 32'h8000_0001};

    // Reset
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; PRDATA = '0; PREADY = 1'b0;
    #3;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    step();

    // Vector table: single transfers, wait states 0..3 (3 is the last before timeout)
    for (int i = 0; i < 4; i++)
      do_xfer($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr, vecs[i].wdata,
              vecs[i].prdata, vecs[i].waits, vecs[i].exp_paddr, vecs[i].exp_rdata);

    // Timeout: PREADY stuck low, expect exactly TO access cycles then error
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; cmd_wdata = '0;
    PRDATA = 32'hFFFF_0000; PREADY = 1'b0;
    step();
    cmd_valid = 1'b0;
    chk("to_setup_psel", PSEL, 1);
    step();
    chk("to_first_penable", PENABLE, 1);
    n_acc = 1; got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (rsp_valid) got = 1'b1;
      else if (PENABLE) n_acc++;
    end
    chk("to_rsp_seen", got, 1);
    chk("to_access_cycles", n_acc, TO);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_psel", PSEL, 0);
    chk("to_penable", PENABLE, 0);
    step();
    chk("to_rsp_pulse", rsp_valid, 0);
    do_xfer("after_to", 1'b0, 32'h24, 32'h0, 32'h0000_5A5A, 0, 32'h24, 32'h0000_5A5A);

    // Back-to-back with cmd_valid held high and a zero-wait completer
    bw[0] = 1'b1; ba[0] = 32'h00; bd[0] = 32'h0000_0111;
    bw[1] = 1'b0; ba[1] = 32'h04; bd[1] = 32'h0000_0222;
    bw[2] = 1'b1; ba[2] = 32'h10; bd[2] = 32'h0000_0333;
    PREADY = 1'b1; PRDATA = 32'h0BAD_0004;
    idx = 0; n_rsp = 0; psel_low = 0;
    for (int c = 1; c <= 12; c++) begin
      if (cmd_ready && idx < 3) begin
        cmd_valid = 1'b1; cmd_write = bw[idx]; cmd_addr = ba[idx]; cmd_wdata = bd[idx];
        exp_q.push_back(bw[idx] ? 32'h0 : 32'h0BAD_0004);
        idx++;
      end else if (cmd_ready) begin
        cmd_valid = 1'b0;
      end
      step();
      if (c <= 9 && !PSEL) psel_low++;
      if (rsp_valid) begin
        n_rsp++;
        chk("b2b_rsp_cycle", c, 3 * n_rsp);
        chk("b2b_rsp_err", rsp_err, 0);
        if (exp_q.size() > 0) chk("b2b_rdata", rsp_rdata, exp_q.pop_front());
      end
    end
    cmd_valid = 1'b0; PREADY = 1'b0;
    chk("b2b_rsp_count", n_rsp, 3);
    chk("b2b_psel_low_cycles", psel_low, 3);
    chk("b2b_queue_empty", exp_q.size(), 0);

    // Busy and misaligned: a second command during the transfer is ignored
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0F; cmd_wdata = 32'h55;
    step();
    cmd_write = 1'b0; cmd_addr = 32'h40; cmd_wdata = 32'h99;
    chk("busy_paddr_aligned", PADDR, 32'h0C);
    chk("busy_setup_ready", cmd_ready, 0);
    step();
    chk("busy_acc_ready", cmd_ready, 0);
    chk("busy_acc_paddr", PADDR, 32'h0C);
    chk("busy_acc_pwdata", PWDATA, 32'h55);
    chk("busy_acc_pwrite", PWRITE, 1);
    step();
    chk("busy_acc2_penable", PENABLE, 1);
    chk("busy_acc2_paddr", PADDR, 32'h0C);
    chk("busy_acc2_pwdata", PWDATA, 32'h55);
    chk("busy_acc2_pwrite", PWRITE, 1);
    cmd_valid = 1'b0; PREADY = 1'b1;
    step();
    PREADY = 1'b0;
    chk("busy_rsp_valid", rsp_valid, 1);
    chk("busy_rsp_err", rsp_err, 0);
    chk("busy_rsp_rdata", rsp_rdata, 0);
    step();
    chk("busy_idle_psel", PSEL, 0);

    // Reset while in ACCESS: outputs clear without waiting for a clock edge
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; PREADY = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    chk("rstacc_penable_before", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("rstacc_psel", PSEL, 0);
    chk("rstacc_penable", PENABLE, 0);
    chk("rstacc_rsp_valid", rsp_valid, 0);
    chk("rstacc_paddr", PADDR, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    chk("rstacc_cmd_ready", cmd_ready, 1);
    PREADY = 1'b1;
    n_rsp = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (rsp_valid) n_rsp++;
    end
    PREADY = 1'b0;
    chk("rstacc_no_rsp", n_rsp, 0);
    chk("rstacc_psel_idle", PSEL, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
